// File: rtl/settings_bus_master.sv
// Avalon-MM master for the settings register/table slave: turns block commands
// into single-word writes or reads with an auto-incrementing address.
module settings_bus_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int T_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] T_LAST = T_LAST_I[TW-1:0];
    localparam logic [2:0] LAT_LAST = RD_LATENCY[2:0];

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_LAT, RD_OUT, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        count;
    logic [TW-1:0]     tcnt;
    logic [2:0]        lcnt;
    logic              last_word;
    logic              timed_out;

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WR_WAIT);
    assign busy      = (state != IDLE);
    assign last_word = (count == 9'd1);
    // The stall counter reaches T_LAST on the TIMEOUT-th consecutive stalled cycle.
    assign timed_out = (TIMEOUT != 0) && (tcnt == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            tcnt          <= '0;
            lcnt          <= '0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr  <= cmd_addr;
                        count <= {cmd_len == 8'd0, cmd_len};
                        tcnt  <= '0;
                        if (cmd_write) begin
                            state <= WR_WAIT;
                        end else begin
                            avm_read    <= 1'b1;
                            avm_address <= cmd_addr;
                            state       <= RD_BUS;
                        end
                    end
                end
                WR_WAIT: begin
                    if (wr_valid) begin
                        avm_writedata <= wr_data;
                        avm_address   <= addr;
                        avm_write     <= 1'b1;
                        state         <= WR_BUS;
                    end
                end
                WR_BUS: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        tcnt      <= '0;
                        addr      <= addr + ADDR_W'(1);
                        count     <= count - 9'd1;
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WR_WAIT;
                        end
                    end else if (timed_out) begin
                        avm_write <= 1'b0;
                        tcnt      <= '0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_BUS: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        tcnt     <= '0;
                        lcnt     <= 3'd1;
                        state    <= RD_LAT;
                    end else if (timed_out) begin
                        avm_read <= 1'b0;
                        tcnt     <= '0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        state    <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_LAT: begin
                    if (lcnt == LAT_LAST) begin
                        rd_data  <= avm_readdata;
                        rd_valid <= 1'b1;
                        state    <= RD_OUT;
                    end else begin
                        lcnt <= lcnt + 3'd1;
                    end
                end
                // Next read is only issued after the consumer takes this word.
                RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        addr     <= addr + ADDR_W'(1);
                        count    <= count - 9'd1;
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            avm_read    <= 1'b1;
                            avm_address <= addr + ADDR_W'(1);
                            state       <= RD_BUS;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_settings_bus_master.sv
// Scoreboard bench for settings_bus_master: directed blocks push expected bus
// writes, read words and done pulses; a monitor pops and compares them.
module tb_settings_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    settings_bus_master #(
        .ADDR_W(16), .DATA_W(32), .RD_LATENCY(1), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
        int          gap;
    } exp_t;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_DONE = 2;

    exp_t        exp_q[$];
    logic [31:0] wr_q[$];
    int          total_checks = 0;
    int          passed_checks = 0;
    int          words_taken = 0;
    int          stall_left = 0;
    logic [15:0] stall_addr = 16'h0;
    logic        stuck = 1'b0;
    int          rd_hold = 0;
    int          last_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_checks++;
        if (act === req) passed_checks++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push_exp(input int kind, input logic [15:0] a, input logic [31:0] d,
                            input logic e, input int gap);
        exp_t x;
        x.kind = kind; x.addr = a; x.data = d; x.err = e; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check({name, "_completes"}, 32'(ok), 32'd1);
        exp_q.delete();
    endtask

    // Slave: waitrequest decided at the falling edge from the visible request.
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (avm_write || avm_read) begin
                if (stuck) avm_waitrequest = 1'b1;
                else if (stall_left > 0 && avm_address == stall_addr) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else avm_waitrequest = 1'b0;
            end else avm_waitrequest = 1'b0;
        end
    end

    // Slave read data: address+1 tagged with A5A5, valid one cycle after acceptance.
    initial begin
        avm_readdata = 32'h0;
        forever begin
            @(posedge clk);
            if (avm_read && !avm_waitrequest)
                avm_readdata = {16'hA5A5, avm_address + 16'd1};
        end
    end

    initial begin
        wr_valid = 1'b0;
        wr_data = 32'h0;
        forever begin
            @(posedge clk);
            if (wr_valid && wr_ready) begin
                void'(wr_q.pop_front());
                words_taken++;
            end
            #1;
            if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data = wr_q[0];
            end else wr_valid = 1'b0;
        end
    end

    initial begin
        rd_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_hold > 0) begin
                rd_ready = 1'b0;
                rd_hold--;
            end else rd_ready = 1'b1;
        end
    end

    // Monitor: pops expectations on bus writes, read handshakes and done pulses.
    initial begin
        int          cyc = 0;
        int          last_req = 0;
        int          run = 0;
        logic        p_stall = 0;
        logic        p_rdwait = 0;
        logic [15:0] p_addr = 0;
        logic [31:0] p_wdata = 0;
        logic [31:0] p_rdata = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (avm_write && avm_read) check("wr_rd_exclusive", 32'd1, 32'd0);
            if (p_stall && (avm_write || avm_read)) begin
                check("stall_addr_stable", 32'(avm_address), 32'(p_addr));
                if (avm_write) check("stall_data_stable", avm_writedata, p_wdata);
            end
            if (p_rdwait) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", rd_data, p_rdata);
            end
            if (rd_valid) check("no_read_while_rd_valid", 32'(avm_read), 32'd0);
            if ((avm_write || avm_read) && avm_waitrequest) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (avm_write || avm_read) last_req = cyc;
            if (avm_write && !avm_waitrequest) begin
                if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("write_kind", 32'(e.kind), 32'(K_WR));
                    check("write_addr", 32'(avm_address), 32'(e.addr));
                    check("write_data", avm_writedata, e.data);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("read_kind", 32'(e.kind), 32'(K_RD));
                    check("read_data", rd_data, e.data);
                end
            end
            if (err && !done) check("err_without_done", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("done_kind", 32'(e.kind), 32'(K_DONE));
                    check("done_err", 32'(err), 32'(e.err));
                    if (e.gap >= 0) check("done_gap", 32'(cyc - last_req), 32'(e.gap));
                    if (e.err) check("timeout_stall_cycles", 32'(last_run), 32'd4);
                end
            end
            p_stall = (avm_write || avm_read) && avm_waitrequest;
            p_addr = avm_address;
            p_wdata = avm_writedata;
            p_rdwait = rd_valid && !rd_ready;
            p_rdata = rd_data;
        end
    end

    initial begin
        int base;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_avm_write", 32'(avm_write), 32'd0);
        check("reset_avm_read", 32'(avm_read), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single write");
        wr_q.push_back(32'h00001234);
        push_exp(K_WR, 16'h0001, 32'h00001234, 1'b0, -1);
        push_exp(K_DONE, 16'h0, 32'h0, 1'b0, 1);
        issue(1'b1, 16'h0001, 8'd1);
        wait_done("single_write");

        $display("[TB] 4-word write with stall on word 2");
        stall_addr = 16'h0011;
        stall_left = 3;
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back(32'h0000_0100 + 32'(i));
            push_exp(K_WR, 16'h0010 + 16'(i), 32'h0000_0100 + 32'(i), 1'b0, -1);
        end
        push_exp(K_DONE, 16'h0, 32'h0, 1'b0, 1);
        issue(1'b1, 16'h0010, 8'd4);
        wait_done("write4");
        check("write4_stall_cycles", 32'(last_run), 32'd3);

        $display("[TB] 2-word read with consumer stall");
        rd_hold = 5;
        push_exp(K_RD, 16'h0, 32'hA5A50001, 1'b0, -1);
        push_exp(K_RD, 16'h0, 32'hA5A50002, 1'b0, -1);
        push_exp(K_DONE, 16'h0, 32'h0, 1'b0, -1);
        issue(1'b0, 16'h0000, 8'd2);
        wait_done("read2");

        $display("[TB] write timeout");
        stuck = 1'b1;
        base = words_taken;
        for (int i = 0; i < 3; i++) wr_q.push_back(32'hDEAD_0000 + 32'(i));
        push_exp(K_DONE, 16'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 16'h0040, 8'd3);
        wait_done("timeout");
        stuck = 1'b0;
        check("timeout_words_taken", 32'(words_taken - base), 32'd1);
        wr_q.delete();
        repeat (2) @(negedge clk);

        $display("[TB] address wrap");
        wr_q.push_back(32'hCAFE0001);
        wr_q.push_back(32'hCAFE0002);
        push_exp(K_WR, 16'hFFFF, 32'hCAFE0001, 1'b0, -1);
        push_exp(K_WR, 16'h0000, 32'hCAFE0002, 1'b0, -1);
        push_exp(K_DONE, 16'h0, 32'h0, 1'b0, 1);
        issue(1'b1, 16'hFFFF, 8'd2);
        wait_done("wrap");

        $display("[TB] reset during read latency");
        issue(1'b0, 16'h0020, 8'd2);
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                if (avm_read && !avm_waitrequest) begin
                    seen = 1;
                    break;
                end
            end
            check("reset_test_read_accepted", 32'(seen), 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_avm_read", 32'(avm_read), 32'd0);
        check("midreset_rd_valid", 32'(rd_valid), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(K_RD, 16'h0, 32'hA5A50006, 1'b0, -1);
        push_exp(K_DONE, 16'h0, 32'h0, 1'b0, -1);
        issue(1'b0, 16'h0005, 8'd1);
        wait_done("after_reset_read");

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/settings_bus_master.md
Name: settings_bus_master

Overview:
- Avalon-MM master that drives the settings register/table slave: set_reg, x/i/fi point registers and the table memories.
- Turns host-side block commands (address, length, direction) into single-word bus writes or reads with auto-incrementing address.
- Sits between the host command/stream front end and the settings block.
- Supports slaves with or without waitrequest, a fixed read latency, and a waitrequest timeout.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 32, bus data width.
- RD_LATENCY, 1, cycles from read acceptance to valid avm_readdata (settings block = 1); legal 1..7.
- TIMEOUT, 255, max consecutive waitrequest cycles before a transfer aborts; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write block, 0 = read block.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  8  word count; 0 means 256.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data accepted when wr_valid&&wr_ready.
- wr_data  in  DATA_W  write data word.
- rd_valid  out  1  read data valid.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  DATA_W  read data word.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at block end.
- err  out  1  one-cycle pulse with done if the block aborted on timeout.
- avm_address  out  ADDR_W  bus address.
- avm_write  out  1  bus write request.
- avm_read  out  1  bus read request.
- avm_writedata  out  DATA_W  bus write data.
- avm_readdata  in  DATA_W  bus read data.
- avm_waitrequest  in  1  slave stall (tie 0 for the settings block).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All registered outputs 0: avm_*, rd_valid, rd_data, done, err, busy.
  - cmd_ready=1 while in IDLE.
- States: IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_LAT, RD_OUT, DONE.
- IDLE:
  - On cmd_valid&&cmd_ready, latch addr, remaining count (0→256) and direction.
  - Go to WR_WAIT if cmd_write=1, otherwise RD_BUS.
- WR_WAIT:
  - wr_ready=1.
  - On wr_valid, latch wr_data into avm_writedata and go to WR_BUS.
- WR_BUS:
  - avm_write=1, avm_address=current addr.
  - Transfer completes in the cycle avm_write&&!avm_waitrequest.
  - On completion: addr+1, count-1; go to WR_WAIT if count remains, else DONE.
  - Zero-wait write throughput is 1 word per 2 cycles.
- RD_BUS:
  - avm_read=1 until accepted (!avm_waitrequest), then go to RD_LAT.
- RD_LAT:
  - Count RD_LATENCY edges from the acceptance edge.
  - Sample avm_readdata into rd_data on the last edge, then go to RD_OUT.
- RD_OUT:
  - rd_valid=1; rd_data held stable until rd_ready.
  - On rd_valid&&rd_ready: addr+1, count-1; go to RD_BUS if count remains, else DONE.
  - Only one read outstanding; no new read is issued while rd_valid is high.
- DONE:
  - done=1 for one cycle, then IDLE.
  - err=1 in the same cycle if the block aborted.
- Address arithmetic:
  - Increment is modulo 2^ADDR_W; 0xFFFF wraps to 0x0000, with no error.
- Timeout:
  - Counter runs while avm_write or avm_read is held with waitrequest=1; cleared on acceptance.
  - When it reaches TIMEOUT: deassert the request the same cycle, discard remaining words, go to DONE with err=1.
  - Read-side consumer sees no rd_valid for the aborted word.
  - Write data not yet fetched is not consumed (wr_ready stays 0).
- avm_write and avm_read are never high together.
- avm_address and avm_writedata are stable while a request is stalled.
- cmd_valid outside IDLE is ignored, since cmd_ready=0.
- Reset mid-block: immediate return to IDLE with all outputs 0; no done pulse; partial transfer is not resumed.

Test Plan:
- Reset, then idle:
  - cmd_ready=1, busy=0, avm_write=avm_read=0, rd_valid=0.
- Single write, waitrequest=0:
  - Stimulus: cmd_write=1, cmd_addr=0x0001, cmd_len=1, wr_data=0x00001234.
  - Response: avm_write high for exactly 1 cycle with address 0x0001 / data 0x00001234; done pulses 1 cycle later; err=0.
- 4-word write from 0x0010 with waitrequest=1 for 3 cycles on word 2:
  - Addresses 0x10..0x13 in order; word 2 address/data held for 4 cycles; one done.
- Read block, cmd_addr=0x0000, cmd_len=2, RD_LATENCY=1:
  - Slave model returns 0xA5A5_0001 then 0xA5A5_0002.
  - rd_ready held 0 for 5 cycles on word 1: rd_data stays 0xA5A50001 and no second avm_read during the stall; then both words delivered, then done.
- Timeout (TIMEOUT=4), write with waitrequest stuck at 1:
  - avm_write drops after 4 stalled cycles; done=err=1 same cycle; remaining words not requested; back to IDLE.
- Wrap and reset:
  - Write cmd_addr=0xFFFF, cmd_len=2: addresses 0xFFFF then 0x0000.
  - Separately, rst=0 during RD_LAT: outputs 0 immediately, no done; the next command runs normally.
